unibus_dma_master: RTL and testbench

- ARM-driven Unibus initiator (bus master), the opposite end of the slave register responders.
- ARM loads an address, a cycle type and optional write data, then sets GO.
- Block requests the bus via NPR/NPG/SACK, becomes master (BBSY), runs one DATI/DATIP/DATO/DATOB cycle with MSYN/SSYN, reports read data or a timeout, then releases the bus.
- CLOCK is 100 MHz; all timing is in CLOCK cycles.

---
 rtl/unibus_dma_master.sv | 183 ++++++++++++++++++
 tb/tb_unibus_dma_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unibus_dma_master.sv
// Unibus NPR bus master: ARM loads address/cycle type/data, sets GO, block arbitrates and runs one DATI/DATIP/DATO/DATOB cycle.
// Optional DMAMASTER_AUTOINC_EN: address post-increments after each successful cycle.
module unibus_dma_master #(
    parameter int DESKEW  = 15,
    parameter int TIMEOUT = 1000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [1:0]  armraddr,
    input  logic [1:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic        init_in_h,
    input  logic        npg_in_h,
    input  logic        bbsy_in_h,
    input  logic        ssyn_in_h,
    input  logic [15:0] d_in_h,
    output logic        npr_out_h,
    output logic        sack_out_h,
    output logic        bbsy_out_h,
    output logic        msyn_out_h,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_SACK = 3'd2;
    localparam logic [2:0] S_ADDR = 3'd3;
    localparam logic [2:0] S_MSYN = 3'd4;
    localparam logic [2:0] S_REL  = 3'd5;

    localparam int CMAX = (TIMEOUT > DESKEW) ? TIMEOUT : DESKEW;
    localparam int CW   = $clog2(CMAX + 1);

    logic [2:0]    state;
    logic          busy;
    logic          timeout;
    logic [1:0]    ctl;
    logic [17:0]   addr;
    logic [15:0]   data;
    logic [CW-1:0] cnt;

    logic unused_wdata;
    assign unused_wdata = ^{armwdata[30], armwdata[27:18]};

    always_comb begin
        armrdata = 32'h0;
        case (armraddr)
            2'd0:    armrdata = 32'h444D1001;
            2'd1:    armrdata = {busy, timeout, ctl, 10'b0, addr};
            2'd2:    armrdata = {16'b0, data};
            default: armrdata = 32'h0;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            ctl        <= 2'b00;
            addr       <= 18'h0;
            data       <= 16'h0;
            cnt        <= '0;
            npr_out_h  <= 1'b0;
            sack_out_h <= 1'b0;
            bbsy_out_h <= 1'b0;
            msyn_out_h <= 1'b0;
            a_out_h    <= 18'h0;
            c_out_h    <= 2'b00;
            d_out_h    <= 16'h0;
        end else if (init_in_h && state != S_IDLE) begin
            // Bus INIT aborts whatever cycle is in flight and flags it as failed
            state      <= S_IDLE;
            busy       <= 1'b0;
            timeout    <= 1'b1;
            cnt        <= '0;
            npr_out_h  <= 1'b0;
            sack_out_h <= 1'b0;
            bbsy_out_h <= 1'b0;
            msyn_out_h <= 1'b0;
            a_out_h    <= 18'h0;
            c_out_h    <= 2'b00;
            d_out_h    <= 16'h0;
        end else begin
            // Saturating so a stalled state can never alias a short count
            if (cnt != '1)
                cnt <= cnt + CW'(1);

            case (state)
                S_IDLE: begin
                    if (armwrite) begin
                        if (armwaddr == 2'd1) begin
                            addr <= armwdata[17:0];
                            ctl  <= armwdata[29:28];
                            if (armwdata[31]) begin
                                timeout   <= 1'b0;
                                busy      <= 1'b1;
                                npr_out_h <= 1'b1;
                                cnt       <= '0;
                                state     <= S_REQ;
                            end
                        end else if (armwaddr == 2'd2) begin
                            data <= armwdata[15:0];
                        end
                    end
                end

                S_REQ: begin
                    if (npg_in_h) begin
                        npr_out_h  <= 1'b0;
                        sack_out_h <= 1'b1;
                        cnt        <= '0;
                        state      <= S_SACK;
                    end
                end

                S_SACK: begin
                    // Previous master must have fully let go before we take the bus
                    if (!npg_in_h && !bbsy_in_h && !ssyn_in_h) begin
                        sack_out_h <= 1'b0;
                        bbsy_out_h <= 1'b1;
                        a_out_h    <= addr;
                        c_out_h    <= ctl;
                        d_out_h    <= ctl[1] ? data : 16'h0;
                        cnt        <= '0;
                        state      <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (cnt == CW'(DESKEW - 1)) begin
                        msyn_out_h <= 1'b1;
                        cnt        <= '0;
                        state      <= S_MSYN;
                    end
                end

                S_MSYN: begin
                    if (ssyn_in_h) begin
                        if (!ctl[1])
                            data <= d_in_h;
                        msyn_out_h <= 1'b0;
                        d_out_h    <= 16'h0;
                        cnt        <= '0;
                        state      <= S_REL;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        timeout    <= 1'b1;
                        msyn_out_h <= 1'b0;
                        d_out_h    <= 16'h0;
                        cnt        <= '0;
                        state      <= S_REL;
                    end
                end

                S_REL: begin
                    // After a timeout there is no slave handshake to wait out
                    if (timeout || !ssyn_in_h) begin
                        bbsy_out_h <= 1'b0;
                        a_out_h    <= 18'h0;
                        c_out_h    <= 2'b00;
                        busy       <= 1'b0;
                        cnt        <= '0;
                        state      <= S_IDLE;
`ifdef DMAMASTER_AUTOINC_EN
                        if (!timeout)
                            addr <= addr + ((ctl == 2'b11) ? 18'd1 : 18'd2);
`endif
                    end
                end

                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unibus_dma_master.sv
// Scoreboard bench for unibus_dma_master: stimulus queues expected bus cycles and register reads, a monitor compares.
module tb_unibus_dma_master;

`ifdef DMAMASTER_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        armwrite = 1'b0;
    logic [1:0]  armraddr = 2'd0;
    logic [1:0]  armwaddr = 2'd0;
    logic [31:0] armwdata = 32'h0;
    logic [31:0] armrdata;
    logic        init_in_h = 1'b0;
    logic        npg_in_h = 1'b0;
    logic        bbsy_in_h = 1'b0;
    logic        ssyn_in_h = 1'b0;
    logic [15:0] d_in_h = 16'h0;
    logic        npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h;

    unibus_dma_master dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
        .armwdata(armwdata), .armrdata(armrdata),
        .init_in_h(init_in_h), .npg_in_h(npg_in_h), .bbsy_in_h(bbsy_in_h),
        .ssyn_in_h(ssyn_in_h), .d_in_h(d_in_h),
        .npr_out_h(npr_out_h), .sack_out_h(sack_out_h), .bbsy_out_h(bbsy_out_h),
        .msyn_out_h(msyn_out_h), .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic [17:0] a;
        logic [1:0]  c;
        logic [15:0] d;
        logic [11:0] msyn_len;   // 0 means unchecked
        logic        abort;
        logic [7:0]  sack_min;
    } bus_exp_t;

    typedef struct packed {
        logic [2:0]  sel;        // 0..3 register, 4 bus output vector
        logic [39:0] exp;
    } rd_exp_t;

    bus_exp_t bus_q[$];
    rd_exp_t  rd_q[$];
    string    rd_nm_q[$];

    int   checks = 0;
    int   errors = 0;
    logic rd_req = 1'b0;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [39:0] busvec();
        return {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, a_out_h, c_out_h, d_out_h};
    endfunction

    // ---------------- monitor ----------------
    int       cyc = 0;
    int       sack_t = 0, bbsy_t = 0, msyn_t = 0;
    logic     p_sack = 0, p_bbsy = 0, p_msyn = 0, p_bbsy_in = 0, p_npg = 0;
    logic     in_cyc = 0, bad = 0;
    bus_exp_t cur;
    rd_exp_t  r;
    string    rn;

    always @(negedge CLOCK) begin
        cyc++;
        if (sack_out_h && !p_sack) sack_t = cyc;
        if (bbsy_out_h && !p_bbsy) begin
            if (bus_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_bus_cycle got addr %h expected none", a_out_h);
                cur = '0;
            end else begin
                cur = bus_q.pop_front();
            end
            chk("sack_hold", 40'(((cyc - sack_t) >= int'(cur.sack_min)) && !sack_out_h), 40'd1);
            chk("bbsy_gate", 40'({p_bbsy_in, p_npg}), 40'd0);
            in_cyc = 1; bad = 0; bbsy_t = cyc;
        end
        if (msyn_out_h && !p_msyn) begin
            chk("deskew", 40'(cyc - bbsy_t), 40'd15);
            msyn_t = cyc;
        end
        if (!msyn_out_h && p_msyn && in_cyc) begin
            chk("addr_ctl_data_hold", 40'(bad), 40'd0);
            if (cur.msyn_len != 0)
                chk("msyn_len", 40'(cyc - msyn_t), 40'(cur.msyn_len));
            chk("d_out_after_msyn", 40'(d_out_h), 40'd0);
            chk("bbsy_after_msyn", 40'(bbsy_out_h), 40'(!cur.abort));
            in_cyc = 0;
        end else if (in_cyc && bbsy_out_h) begin
            if (a_out_h !== cur.a || c_out_h !== cur.c || d_out_h !== cur.d) bad = 1;
        end
        if (!bbsy_out_h && p_bbsy)
            chk("bus_idle_after_release", busvec(), 40'd0);
        if (rd_req) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL read_queue got empty expected entry");
            end else begin
                r  = rd_q.pop_front();
                rn = rd_nm_q.pop_front();
                chk(rn, (r.sel == 3'd4) ? busvec() : {8'h0, armrdata}, r.exp);
            end
        end
        p_sack = sack_out_h; p_bbsy = bbsy_out_h; p_msyn = msyn_out_h;
        p_bbsy_in = bbsy_in_h; p_npg = npg_in_h;
    end

    // ---------------- stimulus helpers (entered at posedge+1) ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic wr(input logic [1:0] wa, input logic [31:0] wd);
        armwrite = 1'b1; armwaddr = wa; armwdata = wd;
        tick(1);
        armwrite = 1'b0;
    endtask

    task automatic probe(input logic [2:0] sel, input logic [39:0] exp, input string nm);
        rd_q.push_back('{sel: sel, exp: exp});
        rd_nm_q.push_back(nm);
        if (sel < 3'd4) armraddr = sel[1:0];
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return npr_out_h;
            1:       return sack_out_h;
            2:       return msyn_out_h;
            default: return bbsy_out_h;
        endcase
    endfunction

    task automatic wait_for(input int which, input logic val, input int limit, input string nm);
        int n = 0;
        while (sig(which) !== val && n < limit) begin
            tick(1);
            n++;
        end
        if (sig(which) !== val) begin
            checks++; errors++;
            $display("FAIL wait_%s got timeout after %0d cycles expected %b", nm, limit, val);
        end
    endtask

    task automatic run_cycle(input logic [17:0] a, input logic [1:0] c, input logic [15:0] dexp,
                             input bit respond, input logic [15:0] sd, input int hold,
                             input int len, input int smin);
        bus_q.push_back('{a: a, c: c, d: dexp, msyn_len: 12'(len), abort: 1'b0, sack_min: 8'(smin)});
        wr(2'd1, {1'b1, 1'b0, c, 10'b0, a});
        wait_for(0, 1'b1, 50, "npr");
        tick(5);
        npg_in_h = 1'b1;
        wait_for(1, 1'b1, 50, "sack");
        npg_in_h = 1'b0;
        if (hold > 0) begin
            bbsy_in_h = 1'b1;
            wr(2'd1, 32'h8003FFFF);
            wr(2'd2, 32'h0000FFFF);
            tick(hold - 2);
            bbsy_in_h = 1'b0;
        end
        wait_for(2, 1'b1, 200, "msyn_rise");
        if (respond) begin
            tick(3);
            ssyn_in_h = 1'b1; d_in_h = sd;
            wait_for(2, 1'b0, 50, "msyn_fall");
            tick(2);
            ssyn_in_h = 1'b0; d_in_h = 16'h0;
        end else begin
            wait_for(2, 1'b0, 1100, "msyn_timeout");
        end
        wait_for(3, 1'b0, 50, "bbsy_release");
        tick(1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tick(3);
        RESET = 1'b0;
        tick(1);
        probe(3'd0, 40'h00444D1001, "reset_id");
        probe(3'd1, 40'h0, "reset_reg1");
        probe(3'd2, 40'h0, "reset_reg2");
        probe(3'd3, 40'h0, "reset_reg3");
        probe(3'd4, 40'h0, "reset_bus");

        // DATI from 777546, slave returns 000200
        run_cycle(18'h3FF66, 2'b00, 16'h0, 1'b1, 16'h0080, 0, 0, 1);
        probe(3'd2, 40'h0000000080, "dati_data");
        probe(3'd1, 40'(32'h00000000 | 32'(18'h3FF66 + (AI ? 18'd2 : 18'd0))), "dati_reg1");
        probe(3'd4, 40'h0, "dati_bus_idle");

        // DATO 123456 to 001000; slave data must not be latched
        wr(2'd2, 32'h0000A72E);
        run_cycle(18'h00200, 2'b10, 16'hA72E, 1'b1, 16'h1234, 0, 0, 1);
        probe(3'd2, 40'h000000A72E, "dato_data_kept");
        probe(3'd1, 40'(32'h20000000 | 32'(18'h00200 + (AI ? 18'd2 : 18'd0))), "dato_reg1");

        // timeout: no SSYN, MSYN high exactly 1000 cycles, no auto-increment
        run_cycle(18'h00040, 2'b00, 16'h0, 1'b0, 16'h0, 0, 1000, 1);
        probe(3'd1, 40'h0040000040, "timeout_reg1");
        probe(3'd2, 40'h000000A72E, "timeout_data_kept");

        // arbitration hold-off with ignored writes while busy (DATIP)
        run_cycle(18'h00100, 2'b01, 16'h0, 1'b1, 16'h5A5A, 20, 0, 20);
        probe(3'd2, 40'h0000005A5A, "arb_data");
        probe(3'd1, 40'(32'h10000000 | 32'(18'h00100 + (AI ? 18'd2 : 18'd0))), "arb_reg1");

        // INIT during MSYN
        bus_q.push_back('{a: 18'h00080, c: 2'b00, d: 16'h0, msyn_len: 12'd0, abort: 1'b1, sack_min: 8'd1});
        wr(2'd1, 32'h80000080);
        wait_for(0, 1'b1, 50, "init_npr");
        tick(5);
        npg_in_h = 1'b1;
        wait_for(1, 1'b1, 50, "init_sack");
        npg_in_h = 1'b0;
        wait_for(2, 1'b1, 200, "init_msyn");
        tick(5);
        init_in_h = 1'b1;
        tick(1);
        init_in_h = 1'b0;
        probe(3'd4, 40'h0, "init_bus_zero");
        probe(3'd1, 40'h0040000080, "init_reg1");
        run_cycle(18'h00080, 2'b00, 16'h0, 1'b1, 16'h1111, 0, 0, 1);
        probe(3'd2, 40'h0000001111, "post_init_data");
        probe(3'd1, 40'(32'(18'h00080 + (AI ? 18'd2 : 18'd0))), "post_init_reg1");

`ifdef DMAMASTER_AUTOINC_EN
        // DATOB pair from 000777, then DATI wrapping from 777776
        wr(2'd2, 32'h000000AB);
        run_cycle(18'h001FF, 2'b11, 16'h00AB, 1'b1, 16'h0, 0, 0, 1);
        probe(3'd1, 40'h0030000200, "autoinc_datob1");
        run_cycle(18'h00200, 2'b11, 16'h00AB, 1'b1, 16'h0, 0, 0, 1);
        probe(3'd1, 40'h0030000201, "autoinc_datob2");
        run_cycle(18'h3FFFE, 2'b00, 16'h0, 1'b1, 16'h2222, 0, 0, 1);
        probe(3'd1, 40'h0, "autoinc_wrap");
`endif

        tick(2);
        chk("scoreboard_drained", 40'(bus_q.size() + rd_q.size()), 40'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1);
    end

endmodule
